// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, state encoding and helpers for the conv33 scan controller
package conv_pkg;
  localparam int CONV_MAX_WIDTH = 640;
  localparam int CONV_MAX_HEIGHT = 480;
  localparam int CONV_WB = $clog2(CONV_MAX_WIDTH + 1);
  localparam int CONV_HB = $clog2(CONV_MAX_HEIGHT + 1);
  localparam int CONV_CB = $clog2(CONV_MAX_WIDTH);
  localparam int CONV_RB = $clog2(CONV_MAX_HEIGHT);
  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_SHARPEN = 2'd1;
  localparam logic [1:0] MODE_GAUSS = 2'd2;
  localparam logic [1:0] MODE_EDGE = 2'd3;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_SWEEP = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE = 3'd4
  } state_t;
  function automatic logic [1:0] mod3_inc(input logic [1:0] x);
    return x == 2'd2 ? 2'd0 : x + 2'd1;
  endfunction
endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: one-line pixel store with one write port and a registered read port
module conv_line_buf import conv_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = CONV_MAX_WIDTH
) (
  input logic clk,
  input logic we,
  input logic [$clog2(DEPTH)-1:0] waddr,
  input logic [WIDTH-1:0] wdata,
  input logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/conv_scan_ctrl.sv
// conv_scan_ctrl: 3x3 conv frame sequencer; define CONV_SCAN_PAD_EN for zero-padded borders
module conv_scan_ctrl import conv_pkg::*; #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_WIDTH = CONV_MAX_WIDTH,
  parameter int MAX_HEIGHT = CONV_MAX_HEIGHT
) (
  input logic clk,
  input logic rst_n,
  input logic start,
  input logic [$clog2(MAX_WIDTH+1)-1:0] cfg_width,
  input logic [$clog2(MAX_HEIGHT+1)-1:0] cfg_height,
  input logic [1:0] cfg_mode,
  input logic [PIXEL_WIDTH-1:0] in_data,
  input logic in_valid,
  output logic in_ready,
  output logic signed [PIXEL_WIDTH-1:0] conv_top,
  output logic signed [PIXEL_WIDTH-1:0] conv_mid,
  output logic signed [PIXEL_WIDTH-1:0] conv_bot,
  output logic [1:0] conv_mode,
  output logic out_valid,
  output logic [$clog2(MAX_HEIGHT)-1:0] out_row,
  output logic [$clog2(MAX_WIDTH)-1:0] out_col,
  output logic out_last,
  output logic busy,
  output logic done,
  output logic cfg_err
);
`ifdef CONV_SCAN_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int WB = $clog2(MAX_WIDTH + 1);
  localparam int HB = $clog2(MAX_HEIGHT + 1);
  localparam int CB = $clog2(MAX_WIDTH);
  localparam int RB = $clog2(MAX_HEIGHT);
  localparam int KB = WB + 1;
  state_t state;
  logic [WB-1:0] w_q;
  logic [HB-1:0] h_q, rows_in;
  logic [CB-1:0] wr_col, col1;
  logic [RB-1:0] r, row1, last_r;
  logic [1:0] rm, rm1, wr_sel;
  logic [KB-1:0] k, last_k;
  logic act, k_last, v0, l0, cok, tok, bok, cfg_ok, row_end;
  logic v1, l1, t1, m1, b1;
  logic [PIXEL_WIDTH-1:0] rd [3];
  assign in_ready = state == S_FILL;
  assign busy = state != S_IDLE;
  assign act = state == S_SWEEP || state == S_FLUSH;
  assign cfg_ok = cfg_width >= WB'(3) && cfg_width <= WB'(MAX_WIDTH) &&
                  cfg_height >= HB'(3) && cfg_height <= HB'(MAX_HEIGHT);
  assign row_end = wr_col == CB'(w_q - WB'(1));
  assign last_k = KB'(w_q) + KB'(2 * PAD) - KB'(1);
  assign last_r = RB'(h_q - HB'(2 - PAD));
  assign k_last = k == last_k;
  assign v0 = act && k >= KB'(2);
  assign l0 = v0 && k_last && r == last_r;
  assign cok = PAD == 0 || (k != '0 && !k_last);
  assign tok = r != '0;
  assign bok = r != RB'(h_q - HB'(1));
  for (genvar g = 0; g < 3; g++) begin : g_lb
    conv_line_buf #(.WIDTH(PIXEL_WIDTH), .DEPTH(MAX_WIDTH)) u_lb (
      .clk(clk),
      .we(in_ready && in_valid && wr_sel == 2'(g)),
      .waddr(wr_col),
      .wdata(in_data),
      .raddr(CB'(k - KB'(PAD))),
      .rdata(rd[g])
    );
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= S_IDLE;
      w_q <= '0;
      h_q <= '0;
      conv_mode <= '0;
      rows_in <= '0;
      wr_col <= '0;
      wr_sel <= '0;
      r <= '0;
      rm <= '0;
      k <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (cfg_ok) begin
            w_q <= cfg_width;
            h_q <= cfg_height;
            conv_mode <= cfg_mode;
            rows_in <= '0;
            wr_col <= '0;
            wr_sel <= '0;
            r <= RB'(1 - PAD);
            rm <= 2'(1 - PAD);
            k <= '0;
            state <= S_FILL;
          end else cfg_err <= 1'b1;
        end
        S_FILL: if (in_valid) begin
          wr_col <= row_end ? '0 : wr_col + 1'b1;
          if (row_end) begin
            rows_in <= rows_in + 1'b1;
            wr_sel <= mod3_inc(wr_sel);
            if (rows_in == HB'(r) + HB'(1)) state <= S_SWEEP;
          end
        end
        S_SWEEP, S_FLUSH: begin
          k <= k_last ? '0 : k + 1'b1;
          if (k_last && state == S_SWEEP && (rows_in != h_q || PAD != 0)) begin
            state <= rows_in != h_q ? S_FILL : S_FLUSH;
            r <= r + 1'b1;
            rm <= mod3_inc(rm);
          end else if (k_last) state <= S_DONE;
        end
        S_DONE: if (done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (!rst_n) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      t1 <= 1'b0;
      m1 <= 1'b0;
      b1 <= 1'b0;
      rm1 <= '0;
      col1 <= '0;
      row1 <= '0;
      conv_top <= '0;
      conv_mid <= '0;
      conv_bot <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_col <= '0;
      out_row <= '0;
      done <= 1'b0;
    end else begin
      v1 <= v0;
      l1 <= l0;
      t1 <= act && cok && tok;
      m1 <= act && cok;
      b1 <= act && cok && bok;
      rm1 <= rm;
      col1 <= v0 ? CB'(k - KB'(1 + PAD)) : '0;
      row1 <= v0 ? r : '0;
      conv_top <= t1 ? rd[mod3_inc(mod3_inc(rm1))] : '0;
      conv_mid <= m1 ? rd[rm1] : '0;
      conv_bot <= b1 ? rd[mod3_inc(rm1)] : '0;
      out_valid <= v1;
      out_last <= l1;
      out_col <= col1;
      out_row <= row1;
      done <= out_last;
    end
endmodule

// File: tb/tb_conv_scan_ctrl.sv
// tb_conv_scan_ctrl: randomized self-checking bench for conv_scan_ctrl against a window-level frame model
module tb_conv_scan_ctrl;
  import conv_pkg::*;
`ifdef CONV_SCAN_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  typedef struct {
    int r;
    int c;
    bit last;
    logic [71:0] win;
  } rec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [CONV_WB-1:0] cfg_width = '0;
  logic [CONV_HB-1:0] cfg_height = '0;
  logic [1:0] cfg_mode = '0;
  logic [7:0] in_data = '0;
  logic in_ready, out_valid, out_last, busy, done, cfg_err;
  logic signed [7:0] conv_top, conv_mid, conv_bot;
  logic [1:0] conv_mode;
  logic [CONV_RB-1:0] out_row;
  logic [CONV_CB-1:0] out_col;
  int n_cmp = 0, n_bad = 0, n_out = 0, err_cnt = 0;
  int fw, fh;
  logic [1:0] fm;
  logic [7:0] img [16][16];
  rec_t exp_q[$];
  rec_t mon_e;
  bit last_prev = 1'b0;
  logic [23:0] h0 = '0, h1 = '0, h2 = '0;
  conv_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .cfg_mode(cfg_mode), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .conv_top(conv_top), .conv_mid(conv_mid), .conv_bot(conv_bot), .conv_mode(conv_mode),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] px(input int y, input int x);
    return (y < 0 || y >= fh || x < 0 || x >= fw) ? 8'd0 : img[y][x];
  endfunction
  always @(negedge clk) begin
    h2 = h1;
    h1 = h0;
    h0 = {conv_top, conv_mid, conv_bot};
    if (cfg_err) err_cnt++;
    if (last_prev || done) chk("done", done, last_prev);
    last_prev = out_last;
    if (out_valid) begin
      n_out++;
      if (exp_q.size() == 0) chk("extra_out", out_valid, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("row", out_row, mon_e.r);
        chk("col", out_col, mon_e.c);
        chk("last", out_last, mon_e.last);
        chk("win", {h2, h1, h0}, mon_e.win);
        chk("mode", conv_mode, fm);
      end
    end else if (out_last) chk("stray_last", out_last, 0);
  end
  task automatic build(input int w, input int h, input logic [1:0] m, input int kind);
    rec_t e;
    int rlo, rhi, clo, chi;
    fw = w;
    fh = h;
    fm = m;
    exp_q.delete();
    if (kind != 4)
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          img[y][x] = kind == 0 ? 8'(y * w + x + 1) : kind == 1 ? 8'd10 :
                      kind == 2 ? ((y == 1 && x == 1) ? 8'd16 : 8'd0) : 8'($urandom);
    rlo = PAD ? 0 : 1;
    rhi = PAD ? h - 1 : h - 2;
    clo = PAD ? 0 : 1;
    chi = PAD ? w - 1 : w - 2;
    for (int r = rlo; r <= rhi; r++)
      for (int c = clo; c <= chi; c++) begin
        e.r = r;
        e.c = c;
        e.last = r == rhi && c == chi;
        e.win = '0;
        for (int dc = 0; dc < 3; dc++)
          for (int dr = 0; dr < 3; dr++) e.win = {e.win[63:0], px(r - 1 + dr, c - 1 + dc)};
        exp_q.push_back(e);
      end
  endtask
  task automatic bad_cfg(input int w, input int h);
    @(posedge clk); #1;
    cfg_width = CONV_WB'(w);
    cfg_height = CONV_HB'(h);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("cfg_err", cfg_err, 1);
    chk("cfg_busy", busy, 0);
    @(posedge clk); #1;
    chk("cfg_err_pulse", cfg_err, 0);
    chk("cfg_idle", busy, 0);
  endtask
  task automatic run_frame(input int w, input int h, input logic [1:0] m, input int kind,
                           input bit gap, input bit poke, input bit abort);
    int idx, cyc, exp_n, err0;
    bit xfer;
    build(w, h, m, kind);
    exp_n = exp_q.size();
    n_out = 0;
    err0 = err_cnt;
    @(posedge clk); #1;
    cfg_width = CONV_WB'(w);
    cfg_height = CONV_HB'(h);
    cfg_mode = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < w * h && cyc < 20000) begin
      in_valid = gap ? (cyc % 2 == 0) : 1'b1;
      in_data = img[idx / w][idx % w];
      if (poke && cyc == 3) begin
        start = 1'b1;
        cfg_width = CONV_WB'(3);
        cfg_mode = ~m;
      end else start = 1'b0;
      @(negedge clk);
      xfer = in_valid && in_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
      if (abort && out_valid) break;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort) begin
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_top", conv_top, 0);
      chk("rst_mid", conv_mid, 0);
      chk("rst_bot", conv_bot, 0);
      chk("rst_mode", conv_mode, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_rowcol", {out_row, out_col, out_last}, 0);
      rst_n = 1'b1;
      exp_q.delete();
      return;
    end
    chk("fill_beats", idx, w * h);
    for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
    chk("done_seen", done, 1);
    @(negedge clk);
    chk("idle_after", busy, 0);
    chk("count", n_out, exp_n);
    chk("leftover", exp_q.size(), 0);
    if (poke) chk("busy_start_err", err_cnt - err0, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("r_ready", in_ready, 0);
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_cfg_err", cfg_err, 0);
    chk("r_valid", out_valid, 0);
    chk("r_last", out_last, 0);
    chk("r_conv", {conv_top, conv_mid, conv_bot}, 0);
    chk("r_mode", conv_mode, 0);
    chk("r_row", out_row, 0);
    chk("r_col", out_col, 0);
    rst_n = 1'b1;
    bad_cfg(2, 5);
    bad_cfg(700, 5);
    bad_cfg(5, 2);
    run_frame(4, 3, MODE_PASS, 0, 0, 0, 0);
    run_frame(5, 5, MODE_EDGE, 1, 0, 0, 0);
    run_frame(3, 3, MODE_GAUSS, 2, 0, 0, 0);
    run_frame(7, 6, MODE_SHARPEN, 3, 0, 0, 0);
    run_frame(7, 6, MODE_SHARPEN, 4, 1, 0, 0);
    run_frame(6, 5, MODE_GAUSS, 3, 0, 1, 0);
    run_frame(8, 6, MODE_EDGE, 3, 0, 0, 1);
    run_frame(5, 4, MODE_PASS, 3, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      run_frame($urandom_range(3, 12), $urandom_range(3, 9), 2'($urandom), 3, 1'($urandom_range(0, 1)), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
